// File: rtl/fifo2linebuf_pkg.sv
// Shared definitions for the video FIFO to line buffer bridge: word field
// positions, parameter defaults and segment FSM state encodings.
package fifo2linebuf_pkg;

    localparam int XHALF_BIT = 27;
    localparam int Y_MSB     = 26;
    localparam int Y_LSB     = 16;
    localparam int PIX_MSB   = 15;

    // Segment key is {x_half, y}
    localparam int KEY_W = XHALF_BIT - Y_LSB + 1;

    localparam int PIX_PER_SEG_DEF = 640;
    localparam int IDX_W_DEF       = 10;
    localparam int SLOT_W_DEF      = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seg_state_t;

endpackage

// File: rtl/fifo2linebuf_slot_tracker.sv
// Per-slot completion tracking: half_done/full flags, release-versus-set
// arbitration and generation of the line_ready pulse.
module linebuf_slot_tracker #(
    parameter int SLOT_W = 2
) (
    input  logic              clk125,
    input  logic              sys_rst,
    input  logic              slot_release,
    input  logic [SLOT_W-1:0] release_slot,
    input  logic [SLOT_W-1:0] q_slot,
    output logic              q_full,
    input  logic              set_vld,
    input  logic [SLOT_W-1:0] set_slot,
    input  logic              set_half,
    input  logic [10:0]       set_y,
    output logic              line_ready,
    output logic [10:0]       line_y
);

    localparam int NSLOT = 1 << SLOT_W;

    logic [NSLOT-1:0][1:0] half_done;
    logic [NSLOT-1:0]      full;
    logic [NSLOT-1:0][1:0] eff_half;
    logic [NSLOT-1:0]      eff_full;
    logic                  other_done;

    // Flags as seen after this cycle's release, so a release in the same
    // cycle as a word for that slot clears it before the word is judged
    always_comb begin
        eff_half = half_done;
        eff_full = full;
        if (slot_release) begin
            eff_half[release_slot] = 2'b00;
            eff_full[release_slot] = 1'b0;
        end
        q_full     = eff_full[q_slot];
        other_done = eff_half[set_slot][~set_half];
    end

    // Flag state update and line completion pulse
    always_ff @(posedge clk125 or posedge sys_rst) begin
        if (sys_rst) begin
            half_done  <= '0;
            full       <= '0;
            line_ready <= 1'b0;
            line_y     <= '0;
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                half_done[i] <= eff_half[i];
                full[i]      <= eff_full[i];
                if (set_vld && (set_slot == SLOT_W'(i))) begin
                    half_done[i][set_half] <= 1'b1;
                    if (other_done)
                        full[i] <= 1'b1;
                end
            end
            line_ready <= set_vld && other_done;
            if (set_vld && other_done)
                line_y <= set_y;
        end
    end

endmodule

// File: rtl/fifo2linebuf.sv
// Pops video words from the receive FIFO, tracks half-line segments keyed
// by {x_half, y}, writes pixels into the slotted line RAM and reports
// completed lines to the scan-out side.
module fifo2linebuf
    import fifo2linebuf_pkg::*;
#(
    parameter int PIX_PER_SEG = PIX_PER_SEG_DEF,
    parameter int IDX_W       = IDX_W_DEF,
    parameter int SLOT_W      = SLOT_W_DEF,
    parameter int ADDR_W      = SLOT_W + 1 + IDX_W
) (
    input  logic              clk125,
    input  logic              sys_rst,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [28:0]       fifo_dout,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    output logic              line_ready,
    output logic [10:0]       line_y,
    input  logic              slot_release,
    input  logic [SLOT_W-1:0] release_slot,
    output logic              drop,
    output logic              seg_err
);

    logic              rd_v;
    seg_state_t        state, state_nxt;
    logic [KEY_W-1:0]  cur_key, cur_key_nxt;
    logic [KEY_W-1:0]  closed_key, closed_key_nxt;
    logic              closed_valid, closed_valid_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt, wr_idx;
    logic              wr, drop_nxt, seg_err_nxt, set_vld, q_full;

    logic [KEY_W-1:0]  key;
    logic              x_half;
    logic [10:0]       y;
    logic [SLOT_W-1:0] slot;
    logic [15:0]       pix;
    logic              unused_rsvd;

    assign key         = fifo_dout[XHALF_BIT:Y_LSB];
    assign x_half      = fifo_dout[XHALF_BIT];
    assign y           = fifo_dout[Y_MSB:Y_LSB];
    assign slot        = fifo_dout[Y_LSB+SLOT_W-1:Y_LSB];
    assign pix         = fifo_dout[PIX_MSB:0];
    assign unused_rsvd = fifo_dout[28];

    // No backpressure: pop whenever the FIFO has data and reset is released
    assign fifo_rd_en = !fifo_empty && !sys_rst;

    // FIFO read data is valid one cycle after the pop
    always_ff @(posedge clk125 or posedge sys_rst) begin
        if (sys_rst)
            rd_v <= 1'b0;
        else
            rd_v <= fifo_rd_en;
    end

    linebuf_slot_tracker #(
        .SLOT_W(SLOT_W)
    ) u_tracker (
        .clk125      (clk125),
        .sys_rst     (sys_rst),
        .slot_release(slot_release),
        .release_slot(release_slot),
        .q_slot      (slot),
        .q_full      (q_full),
        .set_vld     (set_vld),
        .set_slot    (slot),
        .set_half    (x_half),
        .set_y       (y),
        .line_ready  (line_ready),
        .line_y      (line_y)
    );

    // Segment FSM: classify each word as drop, continuation or new segment
    always_comb begin
        state_nxt        = state;
        cur_key_nxt      = cur_key;
        closed_key_nxt   = closed_key;
        closed_valid_nxt = closed_valid;
        idx_nxt          = idx;
        wr               = 1'b0;
        wr_idx           = idx;
        drop_nxt         = 1'b0;
        seg_err_nxt      = 1'b0;
        set_vld          = 1'b0;
        if (rd_v) begin
            if (q_full) begin
                drop_nxt = 1'b1;
            end else if ((state == IDLE) && closed_valid && (key == closed_key)) begin
                drop_nxt = 1'b1;
            end else if ((state == RUN) && (key == cur_key)) begin
                wr      = 1'b1;
                wr_idx  = idx;
                idx_nxt = idx + 1'b1;
            end else begin
                seg_err_nxt = (state == RUN);
                cur_key_nxt = key;
                wr          = 1'b1;
                wr_idx      = '0;
                idx_nxt     = IDX_W'(1);
                state_nxt   = RUN;
            end
            // The last pixel closes the segment before idx can overflow
            if (wr && (wr_idx == IDX_W'(PIX_PER_SEG - 1))) begin
                set_vld          = 1'b1;
                closed_key_nxt   = key;
                closed_valid_nxt = 1'b1;
                state_nxt        = IDLE;
                idx_nxt          = '0;
            end
        end
    end

    // FSM state and registered RAM write / status outputs
    always_ff @(posedge clk125 or posedge sys_rst) begin
        if (sys_rst) begin
            state        <= IDLE;
            cur_key      <= '0;
            closed_key   <= '0;
            closed_valid <= 1'b0;
            idx          <= '0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            drop         <= 1'b0;
            seg_err      <= 1'b0;
        end else begin
            state        <= state_nxt;
            cur_key      <= cur_key_nxt;
            closed_key   <= closed_key_nxt;
            closed_valid <= closed_valid_nxt;
            idx          <= idx_nxt;
            ram_we       <= wr;
            ram_addr     <= {slot, x_half, wr_idx};
            ram_wdata    <= pix;
            drop         <= drop_nxt;
            seg_err      <= seg_err_nxt;
        end
    end

endmodule

// File: tb/tb_fifo2linebuf.sv
// Scoreboard bench for fifo2linebuf: a queue-based FIFO model feeds words,
// expected RAM writes are queued at issue time and checked by a monitor.
module tb_fifo2linebuf;

    logic        clk125 = 1'b0;
    logic        sys_rst = 1'b1;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [28:0] fifo_dout = '0;
    logic        ram_we;
    logic [12:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        line_ready;
    logic [10:0] line_y;
    logic        slot_release = 1'b0;
    logic [1:0]  release_slot = '0;
    logic        drop;
    logic        seg_err;

    typedef struct {
        logic [28:0] data;
        bit          wr;
    } fword_t;

    typedef struct {
        logic [12:0] addr;
        logic [15:0] data;
        bit          lr;
        logic [10:0] ly;
    } exp_t;

    fword_t fq[$];
    exp_t   eq[$];
    int     tq[$];

    int  cyc = 0;
    int  n_chk = 0;
    int  n_fail = 0;
    int  drop_cnt = 0;
    int  seg_cnt = 0;
    int  exp_drop = 0;
    int  exp_seg = 0;
    bit  gap_mode = 0;
    bit  gap = 0;

    fifo2linebuf dut (
        .clk125      (clk125),
        .sys_rst     (sys_rst),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_dout   (fifo_dout),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .line_ready  (line_ready),
        .line_y      (line_y),
        .slot_release(slot_release),
        .release_slot(release_slot),
        .drop        (drop),
        .seg_err     (seg_err)
    );

    always #4 clk125 = ~clk125;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [12:0] mkaddr(input int y, input bit xh, input int idx);
        return {2'(y), xh, 10'(idx)};
    endfunction

    function automatic logic [15:0] mkpix(input int y, input bit xh, input int idx);
        return 16'(y * 1000 + (xh ? 500 : 0) + idx);
    endfunction

    // FIFO model: pop on rd_en, stamp the cycle the write should appear
    always @(posedge clk125) begin
        fword_t w;
        if (fifo_rd_en && fq.size() > 0) begin
            w = fq.pop_front();
            fifo_dout <= w.data;
            if (w.wr)
                tq.push_back(cyc + 2);
        end
        cyc <= cyc + 1;
    end

    // Empty flag, optionally toggled every other cycle
    always @(negedge clk125) begin
        gap = gap_mode ? ~gap : 1'b0;
        fifo_empty = (fq.size() == 0) || gap;
    end

    // Monitor: compare every RAM write against the scoreboard
    always @(negedge clk125) begin
        exp_t e;
        int   st;
        if (!sys_rst) begin
            if (drop)
                drop_cnt++;
            if (seg_err)
                seg_cnt++;
            if (ram_we) begin
                if (eq.size() == 0) begin
                    chk("unexpected_we", 32'(ram_addr), 32'h0);
                end else begin
                    e = eq.pop_front();
                    chk("ram_addr", 32'(ram_addr), 32'(e.addr));
                    chk("ram_wdata", 32'(ram_wdata), 32'(e.data));
                    chk("line_ready", 32'(line_ready), 32'(e.lr));
                    if (e.lr)
                        chk("line_y", 32'(line_y), 32'(e.ly));
                    st = (tq.size() > 0) ? tq.pop_front() : -1;
                    chk("we_latency", 32'(cyc), 32'(st));
                end
            end else if (line_ready) begin
                chk("line_ready_no_we", 32'(line_ready), 32'h0);
            end
        end
    end

    task automatic send(input bit xh, input int y, input int idx, input bit wr, input bit lr);
        fword_t f;
        exp_t   e;
        f.data = {(idx == 7) ? 1'b1 : 1'b0, xh, 11'(y), mkpix(y, xh, idx)};
        f.wr   = wr;
        fq.push_back(f);
        if (wr) begin
            e.addr = mkaddr(y, xh, idx);
            e.data = mkpix(y, xh, idx);
            e.lr   = lr;
            e.ly   = 11'(y);
            eq.push_back(e);
        end
    endtask

    task automatic send_seg(input bit xh, input int y, input int n, input bit lr_last);
        for (int i = 0; i < n; i++)
            send(xh, y, i, 1'b1, lr_last && (i == n - 1));
    endtask

    task automatic drain();
        int n = 0;
        while ((fq.size() != 0 || eq.size() != 0 || tq.size() != 0) && n < 5000) begin
            @(negedge clk125);
            n++;
        end
        repeat (4) @(negedge clk125);
        if (n >= 5000)
            chk("drain_timeout", 32'(n), 32'h0);
    endtask

    task automatic do_release(input int s);
        @(negedge clk125);
        slot_release = 1'b1;
        release_slot = 2'(s);
        @(negedge clk125);
        slot_release = 1'b0;
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_drop"}, 32'(drop_cnt), 32'(exp_drop));
        chk({tag, "_seg_err"}, 32'(seg_cnt), 32'(exp_seg));
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk125);
        #1;
        chk("rst_rd_en", 32'(fifo_rd_en), 32'h0);
        chk("rst_we", 32'(ram_we), 32'h0);
        chk("rst_addr", 32'(ram_addr), 32'h0);
        chk("rst_line_ready", 32'(line_ready), 32'h0);
        chk("rst_line_y", 32'(line_y), 32'h0);
        chk("rst_drop_seg", 32'({drop, seg_err}), 32'h0);
        @(negedge clk125);
        sys_rst = 1'b0;
        repeat (2) @(negedge clk125);

        // Full line y=5 in slot 1
        send_seg(1'b0, 5, 640, 1'b0);
        send_seg(1'b1, 5, 640, 1'b1);
        drain();
        chk("y5_line_y_held", 32'(line_y), 32'd5);
        chk_counts("y5");
        do_release(1);

        // Full line y=2, then a slot-2 word is dropped until released
        send_seg(1'b0, 2, 640, 1'b0);
        send_seg(1'b1, 2, 640, 1'b1);
        drain();
        send(1'b0, 6, 0, 1'b0, 1'b0);
        exp_drop++;
        drain();
        chk_counts("full_slot");
        do_release(2);
        send_seg(1'b0, 6, 640, 1'b0);
        drain();
        chk_counts("after_release");

        // Abandoned segment y=9 x0 after 300 pixels
        send_seg(1'b0, 9, 300, 1'b0);
        send(1'b0, 10, 0, 1'b1, 1'b0);
        exp_seg++;
        drain();
        chk_counts("abandon");
        // Completing the other half of slot 1 must not report a line
        send_seg(1'b1, 9, 640, 1'b0);
        exp_seg++;
        drain();
        chk_counts("no_half0");

        // Duplicate word after closing y=3 x1
        send_seg(1'b1, 3, 640, 1'b0);
        send(1'b1, 3, 640, 1'b0, 1'b0);
        exp_drop++;
        drain();
        chk_counts("dup");

        // Gapped FIFO
        gap_mode = 1'b1;
        send_seg(1'b0, 8, 64, 1'b0);
        drain();
        gap_mode = 1'b0;
        chk_counts("gap");

        // Reset mid-segment at idx 100
        send_seg(1'b0, 11, 100, 1'b0);
        exp_seg++;
        drain();
        chk_counts("pre_reset");
        @(posedge clk125);
        #3;
        sys_rst = 1'b1;
        #1;
        chk("mid_rst_line_y", 32'(line_y), 32'h0);
        chk("mid_rst_outs", 32'({ram_we, line_ready, drop, seg_err, fifo_rd_en}), 32'h0);
        chk("mid_rst_addr_data", 32'({ram_addr, ram_wdata}), 32'h0);
        repeat (2) @(negedge clk125);
        sys_rst = 1'b0;
        repeat (2) @(negedge clk125);
        send(1'b0, 4, 0, 1'b1, 1'b0);
        drain();
        chk_counts("post_reset");
        // Slot 3 half1 was cleared by reset: a fresh half0 reports no line
        send_seg(1'b0, 7, 640, 1'b0);
        exp_seg++;
        drain();
        chk_counts("post_reset_slot3");

        chk("eq_empty", 32'(eq.size()), 32'h0);
        chk("tq_empty", 32'(tq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
